// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the Wishbone IO-port arbiter.
package wb_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TERR = 2'd2
  } arb_state_t;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;
endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    valid = 1'b0;
    // Offset N wraps back to 'last' itself, so a lone requester always wins.
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_io_arbiter.sv
// Round-robin arbiter sharing the wb_intercon IO port between bus masters,
// with grant held for a whole cycle and a per-transfer response watchdog.
module wb_io_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [NUM_MASTERS*WB_AW-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*WB_DW-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*WB_SW-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]       wbm_we_i,
  input  logic [NUM_MASTERS-1:0]       wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]       wbm_stb_i,
  output logic [NUM_MASTERS*WB_DW-1:0] wbm_dat_o,
  output logic [NUM_MASTERS-1:0]       wbm_ack_o,
  output logic [NUM_MASTERS-1:0]       wbm_err_o,
  output logic [NUM_MASTERS-1:0]       wbm_rty_o,
  output logic [WB_AW-1:0]             wbs_adr_o,
  output logic [WB_DW-1:0]             wbs_dat_o,
  output logic [WB_SW-1:0]             wbs_sel_o,
  output logic                         wbs_we_o,
  output logic                         wbs_cyc_o,
  output logic                         wbs_stb_o,
  input  logic [WB_DW-1:0]             wbs_dat_i,
  input  logic                         wbs_ack_i,
  input  logic                         wbs_err_i,
  input  logic                         wbs_rty_i,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic                         timeout_o
);

  localparam int LW = $clog2(NUM_MASTERS);
  localparam bit WDOG_ON = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    WDOG_ON ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t             state_reg;
  logic [NUM_MASTERS-1:0] grant_reg;
  logic [LW-1:0]          last_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   timeout_reg;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_valid;
  logic [LW-1:0]          pick_idx;

  logic [WB_AW-1:0] m_adr;
  logic [WB_DW-1:0] m_dat;
  logic [WB_SW-1:0] m_sel;
  logic             m_we;
  logic             m_cyc;
  logic             m_stb;
  logic             busy;
  logic             terr;
  logic             resp_any;
  logic             wdog_fire;

  wb_rr_picker #(
    .N  (NUM_MASTERS),
    .LW (LW)
  ) u_picker (
    .req   (wbm_cyc_i),
    .last  (last_reg),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (pick_gnt[k]) pick_idx = LW'(k);
    end
  end

  // Grant is one-hot, so a plain priority loop acts as the master mux.
  always_comb begin
    m_adr = '0;
    m_dat = '0;
    m_sel = '0;
    m_we  = 1'b0;
    m_cyc = 1'b0;
    m_stb = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_reg[k]) begin
        m_adr = wbm_adr_i[k*WB_AW +: WB_AW];
        m_dat = wbm_dat_i[k*WB_DW +: WB_DW];
        m_sel = wbm_sel_i[k*WB_SW +: WB_SW];
        m_we  = wbm_we_i[k];
        m_cyc = wbm_cyc_i[k];
        m_stb = wbm_stb_i[k];
      end
    end
  end

  assign busy     = (state_reg == BUSY);
  assign terr     = (state_reg == TERR);
  assign resp_any = wbs_ack_i | wbs_err_i | wbs_rty_i;

  assign wbs_adr_o = busy ? m_adr : '0;
  assign wbs_dat_o = busy ? m_dat : '0;
  assign wbs_sel_o = busy ? m_sel : '0;
  assign wbs_we_o  = busy & m_we;
  assign wbs_cyc_o = busy & m_cyc;
  assign wbs_stb_o = busy & m_stb;

  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign wbm_ack_o = busy ? (grant_reg & {NUM_MASTERS{wbs_ack_i}}) : '0;
  assign wbm_rty_o = busy ? (grant_reg & {NUM_MASTERS{wbs_rty_i}}) : '0;
  assign wbm_err_o = terr ? grant_reg :
                     busy ? (grant_reg & {NUM_MASTERS{wbs_err_i}}) : '0;

  assign grant_o   = grant_reg;
  assign timeout_o = timeout_reg;

  always_comb begin
    if (!wbs_stb_o || resp_any) cnt_next = '0;
    else if (cnt_reg == '1)     cnt_next = cnt_reg;
    else                        cnt_next = cnt_reg + 1'b1;
  end

  assign wdog_fire = WDOG_ON && wbs_stb_o && !resp_any && (cnt_reg == CNT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      last_reg    <= LW'(NUM_MASTERS - 1);
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (pick_valid) begin
            grant_reg <= pick_gnt;
            last_reg  <= pick_idx;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          // Dropping cyc wins over a coincident timeout: the tenure is over.
          if (!m_cyc) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            cnt_reg   <= '0;
          end else if (wdog_fire) begin
            state_reg   <= TERR;
            timeout_reg <= 1'b1;
            cnt_reg     <= '0;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        TERR: begin
          cnt_reg <= '0;
          if (m_cyc) begin
            state_reg <= BUSY;
          end else begin
            state_reg <= IDLE;
            grant_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Scoreboard bench for wb_io_arbiter: two masters, watchdog set to 8 cycles.
module tb_wb_io_arbiter;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N*32-1:0] m_adr, m_dat;
  logic [N*4-1:0]  m_sel;
  logic [N-1:0]    m_we, m_cyc, m_stb;
  logic [N*32-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0]     wbs_adr_o, wbs_dat_o;
  logic [3:0]      wbs_sel_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [31:0]     s_dat;
  logic            s_ack, s_err, s_rty;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  wb_io_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel),
    .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic [N-1:0] ack;
    logic [N-1:0] err;
    logic [N-1:0] rty;
    logic         chk_dat;
    logic [31:0]  dat;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_we[k]  = we;
    m_adr[k*32 +: 32] = adr;
    m_dat[k*32 +: 32] = dat;
    m_sel[k*4 +: 4]   = 4'hF;
  endtask

  task automatic slave(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
    s_ack = ack;
    s_err = err;
    s_rty = rty;
    s_dat = dat;
  endtask

  task automatic clear_all();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    slave(0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input logic [N-1:0] ack, input logic [N-1:0] err, input logic [N-1:0] rty,
                          input logic chk, input logic [31:0] dat);
    exp_t e;
    e.ack = ack; e.err = err; e.rty = rty; e.chk_dat = chk; e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (|{wbm_ack_o, wbm_err_o, wbm_rty_o}) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_all();
    set_m(0, 1, 1, 1, 32'hFFFF_0000, 32'h1234_5678);
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if (grant_o !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    n_cmp++;
    if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, timeout_o} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl: cyc/stb/we/to got %b want 0000", {wbs_cyc_o, wbs_stb_o, wbs_we_o, timeout_o});
    end
    n_cmp++;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 6'b0) begin
      n_bad++; $display("FAIL reset_resp: got %b want 000000", {wbm_ack_o, wbm_err_o, wbm_rty_o});
    end
    n_cmp++;
    if ({wbs_adr_o, wbs_dat_o, wbs_sel_o} !== 68'h0) begin
      n_bad++; $display("FAIL reset_bus: adr %h dat %h sel %h want 0", wbs_adr_o, wbs_dat_o, wbs_sel_o);
    end
    $display("reset: grant=%b cyc=%b", grant_o, wbs_cyc_o);
    step();
    clear_all();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    exp_t e;
    bit seen;
    set_m(0, 1, 1, 0, 32'h0000_1000, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (wbs_cyc_o !== 1'b0) begin n_bad++; $display("FAIL t1_early: wbs_cyc_o got %b want 0", wbs_cyc_o); end
    step();
    @(negedge clk);
    n_cmp++;
    if ({wbs_cyc_o, grant_o} !== 3'b1_01) begin
      n_bad++; $display("FAIL t1_grant: cyc,grant got %b,%b want 1,01", wbs_cyc_o, grant_o);
    end
    n_cmp++;
    if (wbs_adr_o !== 32'h0000_1000) begin n_bad++; $display("FAIL t1_adr: got %h want 00001000", wbs_adr_o); end
    push_exp(2'b01, 2'b00, 2'b00, 1'b1, 32'hDEAD_BEEF);
    step();
    step();
    slave(1, 0, 0, 32'hDEAD_BEEF);
    wait_resp(seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== {e.ack, e.err, e.rty}) begin
      n_bad++; $display("FAIL t1_resp: a/e/r got %b/%b/%b want %b/%b/%b", wbm_ack_o, wbm_err_o, wbm_rty_o, e.ack, e.err, e.rty);
    end
    n_cmp++;
    if (wbm_dat_o[31:0] !== e.dat) begin n_bad++; $display("FAIL t1_data: got %h want %h", wbm_dat_o[31:0], e.dat); end
    $display("t1 read: ack=%b data=%h grant=%b", wbm_ack_o, wbm_dat_o[31:0], grant_o);
    step();
    slave(0, 0, 0, 32'h0);
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    @(negedge clk);
    n_cmp++;
    if (grant_o !== 2'b00) begin n_bad++; $display("FAIL t1_release: grant got %b want 00", grant_o); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit seen;
    logic [1:0] exp_g;
    int k;
    do_reset();
    set_m(0, 1, 1, 0, 32'h2000, 32'h0);
    set_m(1, 1, 1, 0, 32'h3000, 32'h0);
    exp_g = 2'b01;
    for (int r = 0; r < 4; r++) begin
      step();
      @(negedge clk);
      n_cmp++;
      if (grant_o !== exp_g) begin n_bad++; $display("FAIL t2_grant%0d: got %b want %b", r, grant_o, exp_g); end
      push_exp(exp_g, 2'b00, 2'b00, 1'b1, 32'hA0 + r);
      step();
      slave(1, 0, 0, 32'hA0 + r);
      wait_resp(seen);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== {e.ack, e.err, e.rty}) begin
        n_bad++; $display("FAIL t2_resp%0d: a/e/r got %b/%b/%b want %b/%b/%b", r, wbm_ack_o, wbm_err_o, wbm_rty_o, e.ack, e.err, e.rty);
      end
      n_cmp++;
      if (wbm_dat_o[63:32] !== e.dat) begin n_bad++; $display("FAIL t2_data%0d: got %h want %h", r, wbm_dat_o[63:32], e.dat); end
      $display("t2 round %0d: grant=%b ack=%b", r, grant_o, wbm_ack_o);
      k = (exp_g == 2'b01) ? 0 : 1;
      step();
      slave(0, 0, 0, 32'h0);
      set_m(k, 0, 0, 0, 32'h0, 32'h0);
      step();
      set_m(k, 1, 1, 0, 32'h2000 + 32'(k) * 32'h1000, 32'h0);
      @(negedge clk);
      n_cmp++;
      if (grant_o !== 2'b00) begin n_bad++; $display("FAIL t2_idle%0d: grant got %b want 00", r, grant_o); end
      exp_g = ~exp_g;
    end
    step();
    clear_all();
    step();
    step();
  endtask

  task automatic test_burst();
    exp_t e;
    bit seen;
    do_reset();
    set_m(0, 1, 1, 1, 32'h4000, 32'h11);
    step();
    set_m(1, 1, 1, 0, 32'h5000, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (grant_o !== 2'b01) begin n_bad++; $display("FAIL t3_grant0: got %b want 01", grant_o); end
    n_cmp++;
    if ({wbs_we_o, wbs_sel_o, wbs_dat_o} !== {1'b1, 4'hF, 32'h11}) begin
      n_bad++; $display("FAIL t3_wr: we/sel/dat got %b/%h/%h want 1/f/00000011", wbs_we_o, wbs_sel_o, wbs_dat_o);
    end
    for (int b = 0; b < 3; b++) begin
      push_exp(2'b01, 2'b00, 2'b00, 1'b0, 32'h0);
      step();
      slave(1, 0, 0, 32'h0);
      wait_resp(seen);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen || {wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o} !== {e.ack, e.err, e.rty, 2'b01}) begin
        n_bad++; $display("FAIL t3_beat%0d: a/e/r/g got %b/%b/%b/%b want %b/%b/%b/01", b, wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o, e.ack, e.err, e.rty);
      end
      $display("t3 beat %0d: grant=%b ack=%b", b, grant_o, wbm_ack_o);
    end
    step();
    slave(0, 0, 0, 32'h0);
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    @(negedge clk);
    n_cmp++;
    if (grant_o !== 2'b00) begin n_bad++; $display("FAIL t3_idle: got %b want 00", grant_o); end
    step();
    @(negedge clk);
    n_cmp++;
    if ({grant_o, wbs_adr_o} !== {2'b10, 32'h5000}) begin
      n_bad++; $display("FAIL t3_m1: grant/adr got %b/%h want 10/00005000", grant_o, wbs_adr_o);
    end
    push_exp(2'b10, 2'b00, 2'b00, 1'b1, 32'h55);
    step();
    slave(1, 0, 0, 32'h55);
    wait_resp(seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== {e.ack, e.err, e.rty} || wbm_dat_o[63:32] !== e.dat) begin
      n_bad++; $display("FAIL t3_m1resp: a/e/r/d got %b/%b/%b/%h want %b/%b/%b/%h", wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o[63:32], e.ack, e.err, e.rty, e.dat);
    end
    step();
    clear_all();
    step();
    step();
  endtask

  task automatic test_timeout();
    exp_t e;
    bit seen;
    do_reset();
    set_m(0, 1, 1, 0, 32'h6000, 32'h0);
    step();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({wbs_stb_o, timeout_o, wbm_err_o} !== 4'b10_00) begin
        n_bad++; $display("FAIL t4_wait%0d: stb/to/err got %b/%b/%b want 1/0/00", i, wbs_stb_o, timeout_o, wbm_err_o);
      end
      step();
    end
    push_exp(2'b00, 2'b01, 2'b00, 1'b0, 32'h0);
    slave(1, 0, 0, 32'h0);
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    wait_resp(seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== {e.ack, e.err, e.rty}) begin
      n_bad++; $display("FAIL t4_terr: a/e/r got %b/%b/%b want %b/%b/%b", wbm_ack_o, wbm_err_o, wbm_rty_o, e.ack, e.err, e.rty);
    end
    n_cmp++;
    if ({timeout_o, wbs_cyc_o, wbs_stb_o} !== 3'b100) begin
      n_bad++; $display("FAIL t4_flags: to/cyc/stb got %b/%b/%b want 1/0/0", timeout_o, wbs_cyc_o, wbs_stb_o);
    end
    $display("t4 timeout: err=%b timeout=%b cyc=%b", wbm_err_o, timeout_o, wbs_cyc_o);
    step();
    slave(0, 0, 0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if ({timeout_o, wbm_err_o, grant_o} !== 5'b0) begin
      n_bad++; $display("FAIL t4_pulse: to/err/grant got %b/%b/%b want 0/00/00", timeout_o, wbm_err_o, grant_o);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_m(1, 1, 1, 1, 32'h7000, 32'h77);
    step();
    @(negedge clk);
    n_cmp++;
    if (grant_o !== 2'b10) begin n_bad++; $display("FAIL t5_grant: got %b want 10", grant_o); end
    step();
    rst_n = 1'b0;
    slave(1, 0, 0, 32'h99);
    step();
    @(negedge clk);
    n_cmp++;
    if ({grant_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, timeout_o} !== 6'b0) begin
      n_bad++; $display("FAIL t5_ctrl: grant/cyc/stb/we/to got %b/%b/%b/%b/%b want 0", grant_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, timeout_o);
    end
    n_cmp++;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_adr_o} !== 38'h0) begin
      n_bad++; $display("FAIL t5_out: a/e/r/adr got %b/%b/%b/%h want 0", wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_adr_o);
    end
    step();
    rst_n = 1'b1;
    slave(0, 0, 0, 32'h0);
    set_m(0, 1, 1, 0, 32'h8000, 32'h0);
    step();
    @(negedge clk);
    n_cmp++;
    if (grant_o !== 2'b01) begin n_bad++; $display("FAIL t5_first: got %b want 01", grant_o); end
    $display("t5 reset mid-transfer: first grant=%b", grant_o);
    step();
    clear_all();
    step();
    step();
  endtask

  task automatic test_err_rty();
    exp_t e;
    bit seen;
    do_reset();
    set_m(0, 1, 1, 0, 32'h9000, 32'h0);
    set_m(1, 1, 1, 0, 32'hA000, 32'h0);
    step();
    @(negedge clk);
    n_cmp++;
    if (grant_o !== 2'b01) begin n_bad++; $display("FAIL t6_grant0: got %b want 01", grant_o); end
    push_exp(2'b00, 2'b01, 2'b00, 1'b0, 32'h0);
    step();
    slave(0, 1, 0, 32'h0);
    wait_resp(seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== {e.ack, e.err, e.rty}) begin
      n_bad++; $display("FAIL t6_err: a/e/r got %b/%b/%b want %b/%b/%b", wbm_ack_o, wbm_err_o, wbm_rty_o, e.ack, e.err, e.rty);
    end
    $display("t6 err: err=%b", wbm_err_o);
    step();
    slave(0, 0, 0, 32'h0);
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if (grant_o !== 2'b10) begin n_bad++; $display("FAIL t6_grant1: got %b want 10", grant_o); end
    push_exp(2'b00, 2'b00, 2'b10, 1'b0, 32'h0);
    step();
    slave(0, 0, 1, 32'h0);
    wait_resp(seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || {wbm_ack_o, wbm_err_o, wbm_rty_o} !== {e.ack, e.err, e.rty}) begin
      n_bad++; $display("FAIL t6_rty: a/e/r got %b/%b/%b want %b/%b/%b", wbm_ack_o, wbm_err_o, wbm_rty_o, e.ack, e.err, e.rty);
    end
    $display("t6 rty: rty=%b", wbm_rty_o);
    step();
    clear_all();
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within bound");
    $fatal(1, "bench hang");
  end

  initial begin
    rst_n = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    slave(0, 0, 0, 32'h0);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_burst();
    test_timeout();
    test_reset_midflight();
    test_err_rty();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
